// File: rtl/bus_ctrl_pkg.sv
// Shared types and status decode for the processor bus cycle controller.
package bus_ctrl_pkg;

    // Bus cycle phases; TW repeats for wait states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5
    } bus_state_e;

    // CPU status codes as seen on s_n.
    localparam logic [2:0] ST_INTA = 3'b000;
    localparam logic [2:0] ST_IOR  = 3'b001;
    localparam logic [2:0] ST_IOW  = 3'b010;
    localparam logic [2:0] ST_HALT = 3'b011;
    localparam logic [2:0] ST_CODE = 3'b100;
    localparam logic [2:0] ST_MEMR = 3'b101;
    localparam logic [2:0] ST_MEMW = 3'b110;
    localparam logic [2:0] ST_PASV = 3'b111;

    // Command strobe bundle, all active low.
    typedef struct packed {
        logic mrdc_n;
        logic mwtc_n;
        logic amwc_n;
        logic iorc_n;
        logic iowc_n;
        logic aiowc_n;
        logic inta_n;
    } cmd_t;

    localparam cmd_t CMD_IDLE = '{default: 1'b1};

    // Cycles that move data from the bus into the CPU.
    function automatic logic is_read(input logic [2:0] st);
        return (st == ST_INTA) || (st == ST_IOR) ||
               (st == ST_CODE) || (st == ST_MEMR);
    endfunction

    // Cycles that drive CPU data onto the bus.
    function automatic logic is_write(input logic [2:0] st);
        return (st == ST_IOW) || (st == ST_MEMW);
    endfunction

    // Status codes that request a bus cycle (halt and passive do not).
    function automatic logic is_active(input logic [2:0] st);
        return is_read(st) || is_write(st);
    endfunction

endpackage

// File: rtl/ready_sync.sv
// Two-flop synchronizer for the asynchronous slave ready line.
// Resets to 1 so a cycle started right after reset is not stretched.
module ready_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift ready through two flops into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Processor bus cycle controller: status decode, T1-T4 sequencer with
// programmable and READY-driven wait states, ALE/DT-R/DEN and command strobes.
module bus_cycle_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter int READY_SYNC  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] s_n,
    input  logic       aen_n,
    input  logic       cen,
    input  logic       ready,
    output logic       mrdc_n,
    output logic       mwtc_n,
    output logic       amwc_n,
    output logic       iorc_n,
    output logic       iowc_n,
    output logic       aiowc_n,
    output logic       inta_n,
    output logic       ale,
    output logic       dtr,
    output logic       den,
    output logic       busy,
    output logic [2:0] cyc_type
);

    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);

    bus_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          rdy;
    logic          start;
    logic          in_idle;
    logic          data_phase;
    logic          wait_done;
    cmd_t          cmd;

    generate
        if (READY_SYNC != 0) begin : g_sync
            ready_sync u_ready_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (ready),
                .q     (rdy)
            );
        end else begin : g_nosync
            assign rdy = ready;
        end
    endgenerate

    assign in_idle    = (state == IDLE);
    // A cycle needs a passive status since the last one (armed) and an
    // enabled address bus; status is only looked at while idle.
    assign start      = in_idle && armed && is_active(s_n) && !aen_n;
    assign data_phase = (state == T2) || (state == TW) || (state == T3);
    assign wait_done  = (cnt == '0) && rdy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: forced waits first, then hold in TW until ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = T1;
            T1:      state_nxt = T2;
            T2, TW:  state_nxt = wait_done ? T3 : TW;
            T3:      state_nxt = T4;
            T4:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arming: passive status re-arms; any active status seen while idle is
    // consumed, whether or not it launched a cycle, so it is never retried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         armed <= 1'b0;
        else if (s_n == ST_PASV)            armed <= 1'b1;
        else if (in_idle && is_active(s_n)) armed <= 1'b0;
    end

    // Latch the status of the cycle being run; held until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cyc_type <= ST_PASV;
        else if (start) cyc_type <= s_n;
    end

    // Wait counter: loaded in T1, counts down the minimum wait states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == T1) begin
            cnt <= CNT_INIT;
        end else if (((state == T2) || (state == TW)) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Output decode from registered state and cycle type; cen gates everything
    // except busy/cyc_type so the buffers can be tri-stated mid-cycle.
    always_comb begin
        cmd = CMD_IDLE;
        ale = 1'b0;
        dtr = 1'b1;
        den = 1'b0;
        if (cen) begin
            ale = (state == T1);
            if (!in_idle && is_read(cyc_type)) dtr = 1'b0;
            if (is_read(cyc_type))       den = data_phase;
            else if (is_write(cyc_type)) den = data_phase || (state == T1);
            if (data_phase) begin
                case (cyc_type)
                    ST_CODE, ST_MEMR: cmd.mrdc_n  = 1'b0;
                    ST_IOR:           cmd.iorc_n  = 1'b0;
                    ST_INTA:          cmd.inta_n  = 1'b0;
                    ST_MEMW:          cmd.amwc_n  = 1'b0;
                    ST_IOW:           cmd.aiowc_n = 1'b0;
                    default:          ;
                endcase
            end
            // Normal write strobes are late: T3 only, data is stable by then.
            if (state == T3) begin
                if (cyc_type == ST_MEMW) cmd.mwtc_n = 1'b0;
                if (cyc_type == ST_IOW)  cmd.iowc_n = 1'b0;
            end
        end
    end

    assign mrdc_n  = cmd.mrdc_n;
    assign mwtc_n  = cmd.mwtc_n;
    assign amwc_n  = cmd.amwc_n;
    assign iorc_n  = cmd.iorc_n;
    assign iowc_n  = cmd.iowc_n;
    assign aiowc_n = cmd.aiowc_n;
    assign inta_n  = cmd.inta_n;
    assign busy    = !in_idle;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Bench for bus_cycle_ctrl: three configurations share one stimulus stream and
// are checked each cycle against a phase-level model, plus literal scenarios.
module tb_bus_cycle_ctrl;

    localparam int N = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] s_n;
    logic       aen_n;
    logic       cen;
    logic       ready;

    logic [N-1:0] mrdc_n_w, mwtc_n_w, amwc_n_w, iorc_n_w, iowc_n_w, aiowc_n_w, inta_n_w;
    logic [N-1:0] ale_w, dtr_w, den_w, busy_w;
    logic [2:0]   cyc_w [N];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // inst0: WS=0 sync ready; inst1: WS=2 sync ready; inst2: WS=0 raw ready
    function automatic int ws_of(input int i);
        return (i == 1) ? 2 : 0;
    endfunction
    function automatic bit rs_of(input int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        bus_cycle_ctrl #(
            .WAIT_STATES ((g == 1) ? 2 : 0),
            .READY_SYNC  ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .s_n      (s_n),
            .aen_n    (aen_n),
            .cen      (cen),
            .ready    (ready),
            .mrdc_n   (mrdc_n_w[g]),
            .mwtc_n   (mwtc_n_w[g]),
            .amwc_n   (amwc_n_w[g]),
            .iorc_n   (iorc_n_w[g]),
            .iowc_n   (iowc_n_w[g]),
            .aiowc_n  (aiowc_n_w[g]),
            .inta_n   (inta_n_w[g]),
            .ale      (ale_w[g]),
            .dtr      (dtr_w[g]),
            .den      (den_w[g]),
            .busy     (busy_w[g]),
            .cyc_type (cyc_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 T1, 2 wait phase (T2 when k==0, TW after), 3 T3, 4 T4.
    int       m_ph [N];
    int       m_k  [N];
    bit       m_armed [N];
    logic [2:0] m_type [N];
    bit       h1 [N];
    bit       h2 [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_ph[i] = 0; m_k[i] = 0; m_armed[i] = 0; m_type[i] = 3'b111;
                h1[i] = 1; h2[i] = 1;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                bit r;
                r = rs_of(i) ? h2[i] : ready;
                if (m_ph[i] == 0) begin
                    if (s_n == 3'b111) m_armed[i] = 1;
                    else if (s_n != 3'b011) begin
                        if (m_armed[i] && !aen_n) begin
                            m_ph[i] = 1;
                            m_type[i] = s_n;
                        end
                        m_armed[i] = 0;
                    end
                end else begin
                    if (s_n == 3'b111) m_armed[i] = 1;
                    case (m_ph[i])
                        1: begin m_ph[i] = 2; m_k[i] = 0; end
                        2: if (m_k[i] >= ws_of(i) && r) m_ph[i] = 3; else m_k[i]++;
                        3: m_ph[i] = 4;
                        default: m_ph[i] = 0;
                    endcase
                end
                h2[i] = h1[i];
                h1[i] = ready;
            end
        end
    end

    // {ale,dtr,den,busy,cyc_type,mrdc,mwtc,amwc,iorc,iowc,aiowc,inta}
    function automatic logic [13:0] exp_vec(input int i);
        logic [2:0] t;
        bit rd, wr, dat, c;
        logic [13:0] v;
        t   = m_type[i];
        c   = cen;
        rd  = (t == 0) || (t == 1) || (t == 4) || (t == 5);
        wr  = (t == 2) || (t == 6);
        dat = (m_ph[i] == 2) || (m_ph[i] == 3);
        v[13]  = c && (m_ph[i] == 1);
        v[12]  = !(c && (m_ph[i] != 0) && rd);
        v[11]  = c && (rd ? dat : (wr && (dat || m_ph[i] == 1)));
        v[10]  = (m_ph[i] != 0);
        v[9:7] = t;
        v[6]   = !(c && dat && (t == 4 || t == 5));
        v[5]   = !(c && m_ph[i] == 3 && t == 6);
        v[4]   = !(c && dat && t == 6);
        v[3]   = !(c && dat && t == 1);
        v[2]   = !(c && m_ph[i] == 3 && t == 2);
        v[1]   = !(c && dat && t == 2);
        v[0]   = !(c && dat && t == 0);
        return v;
    endfunction

    function automatic logic [13:0] act_vec(input int i);
        return {ale_w[i], dtr_w[i], den_w[i], busy_w[i], cyc_w[i],
                mrdc_n_w[i], mwtc_n_w[i], amwc_n_w[i], iorc_n_w[i],
                iowc_n_w[i], aiowc_n_w[i], inta_n_w[i]};
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                logic [13:0] a, e;
                a = act_vec(i);
                e = exp_vec(i);
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL model_cmp inst%0d t=%0t got=%h want=%h", i, $time, a, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    // Advance to the next cycle, apply inputs for it, let outputs settle.
    task automatic cyc(input logic [2:0] s, input logic a, input logic c, input logic r);
        @(posedge clk);
        #2;
        s_n = s; aen_n = a; cen = c; ready = r;
        #1;
    endtask

    task automatic flush(input int n);
        repeat (n) cyc(3'b111, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b1; s_n = 3'b111; aen_n = 1'b0; cen = 1'b1; ready = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", busy_w[0], 0);
        chk("rst_cyc_type", cyc_w[0], 7);
        chk("rst_strobes", {mrdc_n_w[0], mwtc_n_w[0], amwc_n_w[0], iorc_n_w[0],
                            iowc_n_w[0], aiowc_n_w[0], inta_n_w[0]}, 7'h7f);
        chk("rst_dtr_den_ale", {dtr_w[0], den_w[0], ale_w[0]}, 3'b100);
        @(posedge clk); #2 rst_n = 1'b1;

        // Memory read, inst0 (WS=0, ready=1)
        flush(4);
        cyc(3'b101, 0, 1, 1);
        for (int c = 1; c <= 5; c++) begin
            cyc(3'b111, 0, 1, 1);
            chk($sformatf("mr_ale_c%0d", c), ale_w[0], c == 1);
            chk($sformatf("mr_mrdc_c%0d", c), mrdc_n_w[0], !(c == 2 || c == 3));
            chk($sformatf("mr_dtr_c%0d", c), dtr_w[0], c == 5);
            chk($sformatf("mr_den_c%0d", c), den_w[0], c == 2 || c == 3);
            chk($sformatf("mr_busy_c%0d", c), busy_w[0], c <= 4);
        end

        // Memory write, inst1 (WS=2)
        flush(12);
        cyc(3'b110, 0, 1, 1);
        for (int c = 1; c <= 7; c++) begin
            cyc(3'b111, 0, 1, 1);
            chk($sformatf("mw_amwc_c%0d", c), amwc_n_w[1], !(c >= 2 && c <= 5));
            chk($sformatf("mw_mwtc_c%0d", c), mwtc_n_w[1], !(c == 5));
            chk($sformatf("mw_den_c%0d", c), den_w[1], c <= 5);
            chk($sformatf("mw_dtr_c%0d", c), dtr_w[1], 1);
            chk($sformatf("mw_busy_c%0d", c), busy_w[1], c <= 6);
        end

        // IO read, inst2 (raw ready), ready low cycles 2-4
        flush(12);
        cyc(3'b001, 0, 1, 1);
        for (int c = 1; c <= 8; c++) begin
            cyc(3'b111, 0, 1, !(c >= 2 && c <= 4));
            chk($sformatf("ior_iorc_c%0d", c), iorc_n_w[2], !(c >= 2 && c <= 6));
            chk($sformatf("ior_busy_c%0d", c), busy_w[2], c <= 7);
            chk($sformatf("ior_dtr_c%0d", c), dtr_w[2], c == 8);
        end

        // Held active status: exactly one ALE
        flush(12);
        cnt = 0;
        for (int c = 0; c < 21; c++) begin
            cyc(3'b001, 0, 1, 1);
            cnt += ale_w[0];
        end
        chk("held_single_ale", cnt, 1);

        // Halt: no cycle
        flush(12);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(3'b011, 0, 1, 1);
            cnt += ale_w[0];
        end
        chk("halt_no_ale", cnt, 0);

        // aen_n high at start consumes the status; not retried until passive
        cyc(3'b111, 0, 1, 1);
        cyc(3'b001, 1, 1, 1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            cyc(3'b001, 0, 1, 1);
            cnt += ale_w[0];
        end
        chk("aen_consumed", cnt, 0);
        cyc(3'b111, 0, 1, 1);
        cyc(3'b001, 0, 1, 1);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(3'b111, 0, 1, 1);
            cnt += ale_w[0];
        end
        chk("retry_after_pasv", cnt, 1);

        // INTA with cen low in cycles 2-3
        flush(12);
        cyc(3'b000, 0, 1, 1);
        for (int c = 1; c <= 5; c++) begin
            cyc(3'b111, 0, !(c == 2 || c == 3), 1);
            chk($sformatf("inta_cen_busy_c%0d", c), busy_w[0], c <= 4);
            if (c == 2 || c == 3) begin
                chk($sformatf("inta_cen_strobe_c%0d", c), inta_n_w[0], 1);
                chk($sformatf("inta_cen_den_c%0d", c), den_w[0], 0);
                chk($sformatf("inta_cen_dtr_c%0d", c), dtr_w[0], 1);
            end
        end

        // cen toggled mid-cycle re-enables immediately
        flush(12);
        cyc(3'b000, 0, 1, 1);
        cyc(3'b111, 0, 1, 1);
        cyc(3'b111, 0, 0, 1);
        chk("cen_off_inta", inta_n_w[0], 1);
        cen = 1'b1;
        #1;
        chk("cen_on_inta", inta_n_w[0], 0);
        chk("cen_on_den", den_w[0], 1);

        // Reset during TW of a write, inst1
        flush(12);
        cyc(3'b110, 0, 1, 1);
        for (int c = 1; c <= 3; c++) cyc(3'b111, 0, 1, 1);
        chk("wrst_pre_amwc", amwc_n_w[1], 0);
        rst_n = 1'b0;
        #1;
        chk("wrst_amwc", amwc_n_w[1], 1);
        chk("wrst_mwtc", mwtc_n_w[1], 1);
        chk("wrst_den", den_w[1], 0);
        chk("wrst_dtr", dtr_w[1], 1);
        chk("wrst_busy", busy_w[1], 0);
        @(posedge clk);
        #2;
        s_n = 3'b110;
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(3'b110, 0, 1, 1);
            cnt += ale_w[1];
        end
        chk("wrst_no_rearm", cnt, 0);
        cyc(3'b111, 0, 1, 1);
        cyc(3'b110, 0, 1, 1);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            cyc(3'b111, 0, 1, 1);
            cnt += ale_w[1];
        end
        chk("wrst_rearm", cnt, 1);

        // Randomized traffic, model-checked every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            s_n   = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
            aen_n = ($urandom_range(0, 7) == 0);
            cen   = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 249) != 0);
        end
        rst_n = 1'b1;
        flush(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
